// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt sequencer.
//   ir_idx_t     - 3-bit IR level index
//   pic_state_t  - INTA handshake FSM states
//   vec_byte_t   - vector byte layout {T7..T3, IR index}
//   prio_rank()  - position of an IR level in the rotated priority order
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned VB_W   = 5;

    typedef logic [IDX_W-1:0] ir_idx_t;

    localparam ir_idx_t SPURIOUS_IDX = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ACK1,
        GAP,
        ACK2
    } pic_state_t;

    typedef struct packed {
        logic [VB_W-1:0] base;
        ir_idx_t         idx;
    } vec_byte_t;

    // Rank 0 is the highest priority: the level just after the lowest-priority pointer.
    function automatic ir_idx_t prio_rank(input ir_idx_t idx, input ir_idx_t lp);
        return ir_idx_t'(idx - lp - ir_idx_t'(1));
    endfunction

endpackage

// File: rtl/pic_int_sequencer_if.sv
// Bus between the CPU-side/IRR-side logic and the interrupt sequencer.
// Optional macro PIC_POLL_CMD_EN adds poll_strobe.
//   master : drives irr, imr, inta_n, EOI command, mode bits, vector_base
//   slave  : drives int_out, data_out, data_oe, irr_clr, irr_clr_idx, isr,
//            highest_priority
interface pic_int_sequencer_if;
    import pic_pkg::*;

    logic [NUM_IR-1:0] irr;
    logic [NUM_IR-1:0] imr;
    logic              inta_n;
    logic              eoi_strobe;
    logic              eoi_specific;
    ir_idx_t           eoi_level;
    logic              aeoi;
    logic              rotate_en;
    logic [VB_W-1:0]   vector_base;
`ifdef PIC_POLL_CMD_EN
    logic              poll_strobe;
`endif
    logic              int_out;
    logic [7:0]        data_out;
    logic              data_oe;
    logic              irr_clr;
    ir_idx_t           irr_clr_idx;
    logic [NUM_IR-1:0] isr;
    ir_idx_t           highest_priority;

    modport master (
`ifdef PIC_POLL_CMD_EN
        output poll_strobe,
`endif
        output irr, imr, inta_n, eoi_strobe, eoi_specific, eoi_level,
        output aeoi, rotate_en, vector_base,
        input  int_out, data_out, data_oe, irr_clr, irr_clr_idx, isr,
        input  highest_priority
    );

    modport slave (
`ifdef PIC_POLL_CMD_EN
        input  poll_strobe,
`endif
        input  irr, imr, inta_n, eoi_strobe, eoi_specific, eoi_level,
        input  aeoi, rotate_en, vector_base,
        output int_out, data_out, data_oe, irr_clr, irr_clr_idx, isr,
        output highest_priority
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver: finds the first set bit of i_vec scanning
// from (i_lp + 1) mod 8 upward with wrap-around.
//   i_vec   - request or in-service vector
//   i_lp    - lowest-priority level pointer
//   o_idx   - winning level (0 when none)
//   o_valid - any bit set
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] i_vec,
    input  ir_idx_t           i_lp,
    output ir_idx_t           o_idx,
    output logic              o_valid
);

    ir_idx_t w_pos;

    // Scan lowest priority first so the highest-priority hit overwrites.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = int'(NUM_IR) - 1; k >= 0; k--) begin
            w_pos = ir_idx_t'(i_lp + ir_idx_t'(k) + ir_idx_t'(1));
            if (i_vec[w_pos]) begin
                o_idx   = w_pos;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259A-style interrupt sequencer: masks and prioritises requests against the
// in-service register, raises INT, runs the two-pulse INTA handshake, drives
// the vector byte and processes EOI / automatic EOI.
// Optional macro PIC_POLL_CMD_EN enables the poll command (bus.poll_strobe).
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - pic_int_sequencer_if.slave (requests, INTA, EOI, vector, status)
module pic_int_sequencer
    import pic_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pic_int_sequencer_if.slave   bus
);

    logic [NUM_IR-1:0] w_req;
    ir_idx_t           w_req_idx;
    logic              w_req_valid;
    ir_idx_t           w_isr_idx;
    logic              w_isr_valid;
    logic              w_elig;
    logic              w_fall;
    logic              w_rise;

    pic_state_t        r_state;
    pic_state_t        w_state_nxt;
    ir_idx_t           r_lp;
    ir_idx_t           w_lp_nxt;
    ir_idx_t           r_hp;
    logic              r_elig;
    ir_idx_t           r_idx;
    ir_idx_t           w_idx_nxt;
    logic              r_spur;
    logic              w_spur_nxt;
    logic              r_inta_prev;

    logic              r_int_out;
    logic              w_int_nxt;
    logic [7:0]        r_data_out;
    logic [7:0]        w_dout_nxt;
    logic              r_data_oe;
    logic              w_oe_nxt;
    logic              r_irr_clr;
    logic              w_clr_nxt;
    ir_idx_t           r_irr_clr_idx;
    ir_idx_t           w_clr_idx_nxt;
    logic [NUM_IR-1:0] r_isr;
    logic [NUM_IR-1:0] w_isr_nxt;

    logic              w_set_en;
    ir_idx_t           w_set_idx;
    logic              w_aeoi_clr;
    logic              w_eoi_hit;
    ir_idx_t           w_eoi_lvl;
    logic [NUM_IR-1:0] w_clr_mask;
    logic [NUM_IR-1:0] w_set_mask;

    assign w_req  = bus.irr & ~bus.imr;
    assign w_fall = r_inta_prev & ~bus.inta_n;
    assign w_rise = ~r_inta_prev & bus.inta_n;

    pic_priority_resolver u_req_res (
        .i_vec   (w_req),
        .i_lp    (r_lp),
        .o_idx   (w_req_idx),
        .o_valid (w_req_valid)
    );

    // Same order over the ISR: gives both the nesting level and the NS-EOI target.
    pic_priority_resolver u_isr_res (
        .i_vec   (r_isr),
        .i_lp    (r_lp),
        .o_idx   (w_isr_idx),
        .o_valid (w_isr_valid)
    );

    // Fully nested: winner must outrank the highest level already in service.
    assign w_elig = w_req_valid &&
                    (!w_isr_valid || (prio_rank(w_req_idx, r_lp) < prio_rank(w_isr_idx, r_lp)));

    // Handshake FSM next-state and registered-output next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_int_nxt     = r_int_out;
        w_oe_nxt      = 1'b0;
        w_dout_nxt    = r_data_out;
        w_clr_nxt     = 1'b0;
        w_clr_idx_nxt = r_irr_clr_idx;
        w_idx_nxt     = r_idx;
        w_spur_nxt    = r_spur;
        w_set_en      = 1'b0;
        w_set_idx     = r_hp;
        w_aeoi_clr    = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_elig) begin
                    w_int_nxt   = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                // INT stays up even if the request vanishes; that path ends spurious.
                if (w_fall) begin
                    w_state_nxt = ACK1;
                    if (r_elig) begin
                        w_idx_nxt     = r_hp;
                        w_spur_nxt    = 1'b0;
                        w_set_en      = 1'b1;
                        w_clr_nxt     = 1'b1;
                        w_clr_idx_nxt = r_hp;
                    end else begin
                        w_idx_nxt  = SPURIOUS_IDX;
                        w_spur_nxt = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (w_rise) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (w_fall) begin
                    w_state_nxt = ACK2;
                    w_oe_nxt    = 1'b1;
                    w_dout_nxt  = vec_byte_t'{base: bus.vector_base, idx: r_idx};
                end
            end
            ACK2: begin
                if (w_rise) begin
                    w_state_nxt = IDLE;
                    w_int_nxt   = 1'b0;
                    w_aeoi_clr  = bus.aeoi && !r_spur;
                end else begin
                    w_oe_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_int_nxt   = 1'b0;
            end
        endcase

`ifdef PIC_POLL_CMD_EN
        // Poll returns status instead of a vector and abandons any pending INT.
        if (((r_state == IDLE) || (r_state == PEND)) && bus.poll_strobe) begin
            w_state_nxt = IDLE;
            w_int_nxt   = 1'b0;
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = {r_elig, 4'b0000, r_hp};
            w_set_en    = r_elig;
            w_set_idx   = r_hp;
            w_clr_nxt   = r_elig;
            if (r_elig) begin
                w_clr_idx_nxt = r_hp;
            end
        end
`endif
    end

    // ISR and rotation update: clears first, then sets, so a coinciding set wins.
    always_comb begin
        w_eoi_hit = 1'b0;
        w_eoi_lvl = bus.eoi_level;
        if (bus.eoi_strobe) begin
            if (bus.eoi_specific) begin
                w_eoi_hit = r_isr[bus.eoi_level];
            end else begin
                w_eoi_lvl = w_isr_idx;
                w_eoi_hit = w_isr_valid;
            end
        end

        w_clr_mask = '0;
        if (w_eoi_hit) begin
            w_clr_mask[w_eoi_lvl] = 1'b1;
        end
        if (w_aeoi_clr) begin
            w_clr_mask[r_idx] = 1'b1;
        end

        w_set_mask = '0;
        if (w_set_en) begin
            w_set_mask[w_set_idx] = 1'b1;
        end

        w_isr_nxt = (r_isr & ~w_clr_mask) | w_set_mask;

        w_lp_nxt = r_lp;
        if (bus.rotate_en) begin
            if (w_aeoi_clr) begin
                w_lp_nxt = r_idx;
            end
            if (w_eoi_hit) begin
                w_lp_nxt = w_eoi_lvl;
            end
        end
    end

    // State, resolution and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_lp          <= 3'd7;
            r_hp          <= '0;
            r_elig        <= 1'b0;
            r_idx         <= '0;
            r_spur        <= 1'b0;
            r_inta_prev   <= 1'b1;
            r_int_out     <= 1'b0;
            r_data_out    <= '0;
            r_data_oe     <= 1'b0;
            r_irr_clr     <= 1'b0;
            r_irr_clr_idx <= '0;
            r_isr         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_lp          <= w_lp_nxt;
            r_hp          <= w_req_valid ? w_req_idx : r_hp;
            r_elig        <= w_elig;
            r_idx         <= w_idx_nxt;
            r_spur        <= w_spur_nxt;
            r_inta_prev   <= bus.inta_n;
            r_int_out     <= w_int_nxt;
            r_data_out    <= w_dout_nxt;
            r_data_oe     <= w_oe_nxt;
            r_irr_clr     <= w_clr_nxt;
            r_irr_clr_idx <= w_clr_idx_nxt;
            r_isr         <= w_isr_nxt;
        end
    end

    assign bus.int_out          = r_int_out;
    assign bus.data_out         = r_data_out;
    assign bus.data_oe          = r_data_oe;
    assign bus.irr_clr          = r_irr_clr;
    assign bus.irr_clr_idx      = r_irr_clr_idx;
    assign bus.isr              = r_isr;
    assign bus.highest_priority = r_hp;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer. Stimulus pushes expected irr_clr pulses
// and vector bytes into a scoreboard queue; a negedge monitor pops and compares
// whenever the DUT presents one. Status outputs are checked inline.
module tb_pic_int_sequencer;
    import pic_pkg::*;

    typedef struct {
        bit         is_data;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    pic_int_sequencer_if bus ();

    pic_int_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eoi(input bit spec, input ir_idx_t lvl);
        bus.eoi_strobe   = 1'b1;
        bus.eoi_specific = spec;
        bus.eoi_level    = lvl;
        step();
        bus.eoi_strobe   = 1'b0;
        bus.eoi_specific = 1'b0;
    endtask

    // Full two-pulse INTA; optionally a specific EOI for level 6 on the first fall.
    task automatic ack(input bit clr_exp, input ir_idx_t clr_idx, input logic [7:0] data_exp,
                       input logic [7:0] irr_after, input bit eoi_fall);
        exp_t e;
        if (clr_exp) begin
            e.is_data = 1'b0;
            e.val     = 8'(clr_idx);
            sb.push_back(e);
        end
        bus.inta_n = 1'b0;
        if (eoi_fall) begin
            bus.eoi_strobe   = 1'b1;
            bus.eoi_specific = 1'b1;
            bus.eoi_level    = 3'd6;
        end
        step();
        bus.eoi_strobe   = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.irr          = irr_after;
        bus.inta_n       = 1'b1;
        step();
        e.is_data = 1'b1;
        e.val     = data_exp;
        sb.push_back(e);
        bus.inta_n = 1'b0;
        step();
        step();
        bus.inta_n = 1'b1;
        step();
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        bit   prev_oe;
        prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.irr_clr === 1'b1) begin
                if (sb.size() == 0 || sb[0].is_data) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL irr_clr: unexpected pulse idx %0d, expected none here", bus.irr_clr_idx);
                end else begin
                    e = sb.pop_front();
                    chk("irr_clr_idx", 8'(bus.irr_clr_idx), e.val);
                end
            end
            if (bus.data_oe === 1'b1 && !prev_oe) begin
                if (sb.size() == 0 || !sb[0].is_data) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL data_out: unexpected vector 0x%0h, expected none here", bus.data_out);
                end else begin
                    e = sb.pop_front();
                    chk("data_out", bus.data_out, e.val);
                end
            end
            prev_oe = (bus.data_oe === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_chk            = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.irr          = '0;
        bus.imr          = '0;
        bus.inta_n       = 1'b1;
        bus.eoi_strobe   = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level    = '0;
        bus.aeoi         = 1'b0;
        bus.rotate_en    = 1'b0;
        bus.vector_base  = 5'h08;
`ifdef PIC_POLL_CMD_EN
        bus.poll_strobe  = 1'b0;
`endif
        step();
        step();
        chk("rst int_out", 8'(bus.int_out), 8'h00);
        chk("rst data_oe", 8'(bus.data_oe), 8'h00);
        chk("rst data_out", bus.data_out, 8'h00);
        chk("rst isr", bus.isr, 8'h00);
        chk("rst hp", 8'(bus.highest_priority), 8'h00);
        reset = 1'b0;
        step();

        // Basic IR5 service with 2-cycle INT latency.
        bus.irr = 8'h20;
        step();
        chk("s1 int_out lat1", 8'(bus.int_out), 8'h00);
        chk("s1 hp", 8'(bus.highest_priority), 8'h05);
        step();
        chk("s1 int_out lat2", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd5, 8'h45, 8'h00, 1'b0);
        chk("s1 int_out end", 8'(bus.int_out), 8'h00);
        chk("s1 data_oe end", 8'(bus.data_oe), 8'h00);
        chk("s1 isr", bus.isr, 8'h20);
        eoi(1'b0, 3'd0);
        chk("s1 isr after eoi", bus.isr, 8'h00);

        // Nesting: IR2 in service, IR0 preempts, IR5 blocked until both EOIs.
        bus.irr = 8'h04;
        step();
        step();
        chk("s2 int IR2", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd2, 8'h42, 8'h00, 1'b0);
        chk("s2 isr IR2", bus.isr, 8'h04);
        bus.irr = 8'h21;
        step();
        chk("s2 hp IR0", 8'(bus.highest_priority), 8'h00);
        step();
        chk("s2 int IR0", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd0, 8'h40, 8'h20, 1'b0);
        chk("s2 isr IR0+IR2", bus.isr, 8'h05);
        step();
        step();
        chk("s2 IR5 blocked", 8'(bus.int_out), 8'h00);
        chk("s2 hp IR5", 8'(bus.highest_priority), 8'h05);
        eoi(1'b0, 3'd0);
        chk("s2 ns eoi", bus.isr, 8'h04);
        step();
        step();
        chk("s2 IR5 still blocked", 8'(bus.int_out), 8'h00);
        eoi(1'b0, 3'd0);
        chk("s2 ns eoi 2", bus.isr, 8'h00);
        step();
        chk("s2 int IR5 lat1", 8'(bus.int_out), 8'h00);
        step();
        chk("s2 int IR5 lat2", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd5, 8'h45, 8'h00, 1'b0);
        chk("s2 isr IR5", bus.isr, 8'h20);
        eoi(1'b0, 3'd0);
        chk("s2 final isr", bus.isr, 8'h00);
        eoi(1'b0, 3'd0);
        chk("s2 eoi on empty", bus.isr, 8'h00);

        // Spurious: request disappears before the first INTA.
        bus.irr = 8'h08;
        step();
        step();
        chk("s3 int", 8'(bus.int_out), 8'h01);
        bus.irr = 8'h00;
        step();
        step();
        chk("s3 int held", 8'(bus.int_out), 8'h01);
        chk("s3 hp held", 8'(bus.highest_priority), 8'h03);
        ack(1'b0, 3'd0, 8'h47, 8'h00, 1'b0);
        chk("s3 isr", bus.isr, 8'h00);
        chk("s3 int end", 8'(bus.int_out), 8'h00);

        // AEOI with rotation: IR3 becomes lowest priority, IR4 beats IR0.
        bus.aeoi      = 1'b1;
        bus.rotate_en = 1'b1;
        bus.irr       = 8'h08;
        step();
        step();
        chk("s4 int", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd3, 8'h43, 8'h00, 1'b0);
        chk("s4 isr aeoi", bus.isr, 8'h00);
        bus.irr = 8'h11;
        step();
        chk("s4 hp rotated", 8'(bus.highest_priority), 8'h04);
        step();
        ack(1'b1, 3'd4, 8'h44, 8'h00, 1'b0);
        chk("s4 isr aeoi 2", bus.isr, 8'h00);
        bus.aeoi      = 1'b0;
        bus.rotate_en = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s4 rst hp", 8'(bus.highest_priority), 8'h00);
        chk("s4 rst data_out", bus.data_out, 8'h00);
        chk("s4 rst clr_idx", 8'(bus.irr_clr_idx), 8'h00);

        // Specific EOI for IR6 on the same cycle IR6 enters service: set wins.
        bus.irr = 8'h40;
        step();
        step();
        chk("s5 int", 8'(bus.int_out), 8'h01);
        ack(1'b1, 3'd6, 8'h46, 8'h00, 1'b1);
        chk("s5 isr set wins", bus.isr, 8'h40);
        eoi(1'b1, 3'd6);
        chk("s5 specific eoi", bus.isr, 8'h00);
        eoi(1'b1, 3'd6);
        chk("s5 eoi clear bit", bus.isr, 8'h00);

        // Reset during GAP aborts; later INTA without a request is ignored.
        bus.irr = 8'h02;
        step();
        step();
        chk("s6 int", 8'(bus.int_out), 8'h01);
        sb.push_back('{1'b0, 8'h01});
        bus.inta_n = 1'b0;
        step();
        chk("s6 isr ack1", bus.isr, 8'h02);
        bus.irr    = 8'h00;
        bus.inta_n = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s6 rst int", 8'(bus.int_out), 8'h00);
        chk("s6 rst oe", 8'(bus.data_oe), 8'h00);
        chk("s6 rst isr", bus.isr, 8'h00);
        bus.inta_n = 1'b0;
        step();
        bus.inta_n = 1'b1;
        step();
        step();
        chk("s6 stray inta int", 8'(bus.int_out), 8'h00);
        chk("s6 stray inta isr", bus.isr, 8'h00);

        // Masked request never raises INT.
        bus.imr = 8'h02;
        bus.irr = 8'h02;
        step();
        step();
        step();
        chk("s7 masked int", 8'(bus.int_out), 8'h00);
        bus.irr = 8'h00;
        bus.imr = 8'h00;
        step();

        chk("scoreboard drained", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
